// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction memory, redirect and decoder signals of the fetch stage
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    modport master (
        output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential PC fetch with credit-limited requests and a PC-tagged instruction FIFO
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic               clk,
    input logic               rst_n,
    instr_fetch_unit_if.master ifu
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, tgt;
    logic [CW-1:0] cnt_q, cnt_d, out_q, out_d, drop_q, drop_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [63:0]   mem_q [DEPTH];
    logic          run_q, acc, push, pop, dropping;
    // Outputs and next state; a redirect flushes the FIFO and turns every outstanding response into a drop
    always_comb begin
        tgt                = {ifu.redirect_pc[31:2], 2'b00};
        ifu.imem_req_valid = run_q && !ifu.redirect_valid && (({1'b0, out_q} + {1'b0, cnt_q}) < (CW+1)'(DEPTH));
        ifu.imem_addr      = fetch_pc_q;
        ifu.instr_valid    = cnt_q != '0;
        ifu.instr          = mem_q[rd_q][31:0];
        ifu.instr_pc       = mem_q[rd_q][63:32];
        acc                = ifu.imem_req_valid && ifu.imem_req_ready;
        pop                = ifu.instr_valid && ifu.instr_ready;
        dropping           = drop_q != '0;
        push               = ifu.imem_resp_valid && !dropping && !ifu.redirect_valid;
        out_d              = out_q + CW'(acc) - CW'(ifu.imem_resp_valid);
        fetch_pc_d         = ifu.redirect_valid ? tgt : fetch_pc_q + (acc ? 32'd4 : 32'd0);
        resp_pc_d          = ifu.redirect_valid ? tgt : resp_pc_q + (push ? 32'd4 : 32'd0);
        drop_d             = ifu.redirect_valid ? out_d : drop_q - CW'(ifu.imem_resp_valid && dropping);
        cnt_d              = ifu.redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
        wr_d               = ifu.redirect_valid ? '0 : wr_q + AW'(push);
        rd_d               = ifu.redirect_valid ? '0 : rd_q + AW'(pop);
    end
    // Control state; run_q holds requests off while reset is asserted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            cnt_q      <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            cnt_q      <= cnt_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end
    // FIFO storage of {pc, instruction}; cleared on reset so the decoder sees zeros while held in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else if (push) begin
            mem_q[wr_q] <= {resp_pc_q, ifu.imem_resp_data};
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table, reset corner and randomized run against an epoch-tagged scoreboard
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;
    typedef struct {
        logic rr, rv, ir, rd;
        logic [31:0] rpc;
        logic e_rq;
        logic [31:0] e_addr;
        logic e_iv;
        logic [31:0] e_pc;
    } vec_t;
    typedef struct { logic [31:0] addr; int unsigned ep; int unsigned due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    instr_fetch_unit_if bus();
    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (.clk(clk), .rst_n(rst_n), .ifu(bus));
    req_t mq[$];
    ent_t sb[$];
    vec_t tbl[34];
    int unsigned cyc = 0, epoch = 0, delivered = 0, n_cmp = 0, n_bad = 0;
    logic [31:0] exp_req = 32'h0;
    logic rv_r;
    logic [31:0] rpc_r;

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rr, rv, ir, rd, input logic [31:0] rpc,
                               input logic e_rq, input logic [31:0] e_addr, input logic e_iv, input logic [31:0] e_pc);
        v = '{rr, rv, ir, rd, rpc, e_rq, e_addr, e_iv, e_pc};
    endfunction

    task automatic idle();
        bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_data = 0;
        bus.instr_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    endtask

    // One clock: memory returns the oldest request; responses are kept only if issued in the current epoch
    task automatic cycle(input logic rr, rv, ir, rd, input logic [31:0] rpc);
        req_t r;
        logic [31:0] d;
        logic exp_rq;
        @(posedge clk); #1;
        d = $urandom;
        r = '{32'h0, epoch + 1, 0};
        if (rv && mq.size() != 0) r = mq.pop_front();
        bus.imem_req_ready = rr; bus.imem_resp_valid = rv; bus.imem_resp_data = d;
        bus.instr_ready = ir; bus.redirect_valid = rd; bus.redirect_pc = rpc;
        @(negedge clk);
        exp_rq = !rd && (mq.size() + int'(rv) + sb.size() < DEPTH);
        chk("req_valid", bus.imem_req_valid, exp_rq);
        if (bus.imem_req_valid) begin
            chk("req_addr", bus.imem_addr, exp_req);
            if (rr) begin
                mq.push_back('{bus.imem_addr, epoch, cyc + 1 + $urandom_range(3)});
                exp_req = exp_req + 32'd4;
            end
        end
        chk("instr_valid", bus.instr_valid, sb.size() != 0);
        if (bus.instr_valid && ir && sb.size() != 0) begin
            chk("instr_pc", bus.instr_pc, sb[0].pc);
            chk("instr", bus.instr, sb[0].data);
            void'(sb.pop_front());
            delivered++;
        end
        if (rv && r.ep == epoch && !rd) sb.push_back('{r.addr, d});
        if (rd) begin
            sb.delete();
            epoch++;
            exp_req = {rpc[31:2], 2'b00};
        end
        cyc++;
    endtask

    initial begin
        idle();
        tbl[0]  = v(1,0,1,0,0,            1,32'h0,0,0);
        tbl[1]  = v(1,1,1,0,0,            1,32'h4,0,0);
        tbl[2]  = v(1,1,0,0,0,            1,32'h8,1,32'h0);
        tbl[3]  = v(1,1,0,0,0,            1,32'hC,1,32'h0);
        tbl[4]  = v(1,1,0,0,0,            0,32'h10,1,32'h0);
        tbl[5]  = v(1,0,0,0,0,            0,32'h10,1,32'h0);
        tbl[6]  = v(1,0,1,0,0,            0,32'h10,1,32'h0);
        tbl[7]  = v(1,0,1,0,0,            1,32'h10,1,32'h4);
        tbl[8]  = v(0,1,1,0,0,            1,32'h14,1,32'h8);
        tbl[9]  = v(0,0,1,0,0,            1,32'h14,1,32'hC);
        tbl[10] = v(0,0,1,0,0,            1,32'h14,1,32'h10);
        tbl[11] = v(0,0,1,0,0,            1,32'h14,0,0);
        tbl[12] = v(1,0,1,0,0,            1,32'h14,0,0);
        tbl[13] = v(1,0,1,0,0,            1,32'h18,0,0);
        tbl[14] = v(1,0,1,0,0,            1,32'h1C,0,0);
        tbl[15] = v(0,1,1,1,32'h100,      0,32'h20,0,0);
        tbl[16] = v(1,1,1,0,0,            1,32'h100,0,0);
        tbl[17] = v(0,1,1,0,0,            1,32'h104,0,0);
        tbl[18] = v(0,1,1,0,0,            1,32'h104,0,0);
        tbl[19] = v(0,0,0,0,0,            1,32'h104,1,32'h100);
        tbl[20] = v(1,0,0,0,0,            1,32'h104,1,32'h100);
        tbl[21] = v(1,0,0,0,0,            1,32'h108,1,32'h100);
        tbl[22] = v(0,1,1,1,32'h103,      0,32'h10C,1,32'h100);
        tbl[23] = v(1,1,1,0,0,            1,32'h100,0,0);
        tbl[24] = v(0,1,1,0,0,            1,32'h104,0,0);
        tbl[25] = v(0,0,1,0,0,            1,32'h104,1,32'h100);
        tbl[26] = v(0,0,1,1,32'hFFFF_FFFC,0,32'h104,0,0);
        tbl[27] = v(1,0,1,0,0,            1,32'hFFFF_FFFC,0,0);
        tbl[28] = v(1,1,1,0,0,            1,32'h0,0,0);
        tbl[29] = v(0,1,1,0,0,            1,32'h4,1,32'hFFFF_FFFC);
        tbl[30] = v(0,0,0,0,0,            1,32'h4,1,32'h0);
        tbl[31] = v(1,0,0,0,0,            1,32'h4,1,32'h0);
        tbl[32] = v(0,1,0,0,0,            1,32'h8,1,32'h0);
        tbl[33] = v(0,0,0,0,0,            1,32'h8,1,32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_req_valid", bus.imem_req_valid, 0);
        chk("reset_instr_valid", bus.instr_valid, 0);
        chk("reset_instr", bus.instr, 0);
        chk("reset_instr_pc", bus.instr_pc, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 34; i++) begin
            cycle(tbl[i].rr, tbl[i].rv, tbl[i].ir, tbl[i].rd, tbl[i].rpc);
            chk("tbl_req_valid", bus.imem_req_valid, tbl[i].e_rq);
            chk("tbl_addr", bus.imem_addr, tbl[i].e_addr);
            chk("tbl_instr_valid", bus.instr_valid, tbl[i].e_iv);
            if (tbl[i].e_iv) chk("tbl_instr_pc", bus.instr_pc, tbl[i].e_pc);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        idle();
        #1;
        chk("midrst_req_valid", bus.imem_req_valid, 0);
        chk("midrst_instr_valid", bus.instr_valid, 0);
        chk("midrst_instr", bus.instr, 0);
        chk("midrst_instr_pc", bus.instr_pc, 0);
        mq.delete();
        sb.delete();
        epoch++;
        exp_req = 32'h0;
        @(negedge clk) rst_n = 1'b1;
        cycle(1, 0, 1, 0, 0);
        chk("restart_req_valid", bus.imem_req_valid, 1);
        chk("restart_addr", bus.imem_addr, 32'h0);
        for (int k = 0; k < 3000; k++) begin
            rv_r = (mq.size() != 0) ? (mq[0].due <= cyc && $urandom_range(3) != 0) : 1'b0;
            rpc_r = ($urandom_range(2) == 0) ? $urandom
                  : ($urandom_range(1) != 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : 32'($urandom_range(1023));
            cycle($urandom_range(3) != 0, rv_r, $urandom_range(2) != 0, $urandom_range(15) == 0, rpc_r);
        end
        chk("throughput", delivered > 200, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
